// File: rtl/ne_decoder_defs.sv
// Shared definitions for the NE decoder frame sequencer: state encoding,
// default widths/limits and a small saturating-increment helper.
package ne_decoder_defs;

    localparam int LOADCOUNT_DEF    = 17;
    localparam int MAXITER_DEF      = 8;
    localparam int ITERWIDTH_DEF    = 4;
    localparam int LOAD_TIMEOUT_DEF = 64;
    localparam int FRAMEWIDTH_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DECODE = 3'd2,
        ST_UWAIT  = 3'd3,
        ST_UNLOAD = 3'd4
    } ne_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/ne_decode_sequencer_rise_detect.sv
// Registered 1-bit rising-edge detector: rise is high in the cycle d is 1
// after having been 0 on the previous clock edge.
module ne_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_d;
    logic d_q;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/ne_decode_sequencer.sv
// Frame-level controller for the NE decoder: LOAD -> DECODE -> UNLOAD per frame,
// with iteration counting, early termination on syndrome pass and a load watchdog.
module ne_decode_sequencer
    import ne_decoder_defs::*;
#(
    parameter int LOADCOUNT    = LOADCOUNT_DEF,
    parameter int MAXITER      = MAXITER_DEF,
    parameter int ITERWIDTH    = ITERWIDTH_DEF,
    parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF,
    parameter int FRAMEWIDTH   = FRAMEWIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid,
    input  logic                  load_done,
    input  logic                  iter_done,
    input  logic                  syndrome_ok,
    input  logic                  unload_ready,
    input  logic                  unload_done,
    output logic                  frame_ack,
    output logic                  load_start,
    output logic                  decode_start,
    output logic                  unload_start,
    output logic [ITERWIDTH-1:0]  iter_count,
    output logic                  converged,
    output logic                  busy,
    output logic                  load_err,
    output logic [FRAMEWIDTH-1:0] frame_count
);

    localparam int WDOG_W = $clog2(LOAD_TIMEOUT + 1);

    if (MAXITER < 1 || MAXITER >= (1 << ITERWIDTH) || LOAD_TIMEOUT < 1 || LOADCOUNT < 1)
    begin : g_bad_params
        $error("ne_decode_sequencer: illegal parameter combination");
    end

    logic ld_rise;

    ne_rise_detect u_ld_rise (
        .clk  (clk),
        .rst  (rst),
        .d    (load_done),
        .rise (ld_rise)
    );

    ne_state_e             state_q, state_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  frame_ack_q, frame_ack_d;
    logic                  load_start_q, load_start_d;
    logic                  decode_start_q, decode_start_d;
    logic                  unload_start_q, unload_start_d;
    logic [ITERWIDTH-1:0]  iter_count_q, iter_count_d;
    logic                  converged_q, converged_d;
    logic                  busy_q, busy_d;
    logic                  load_err_q, load_err_d;
    logic [FRAMEWIDTH-1:0] frame_count_q, frame_count_d;
    logic [ITERWIDTH-1:0]  iter_next;

    always_comb begin
        state_d        = state_q;
        wdog_d         = wdog_q;
        frame_ack_d    = 1'b0;
        load_start_d   = load_start_q;
        decode_start_d = 1'b0;
        unload_start_d = 1'b0;
        iter_count_d   = iter_count_q;
        converged_d    = converged_q;
        load_err_d     = load_err_q;
        frame_count_d  = frame_count_q;
        iter_next      = ITERWIDTH'(sat_inc(32'(iter_count_q), 32'(MAXITER)));

        case (state_q)
            ST_IDLE: begin
                load_start_d = 1'b0;
                if (frame_valid) begin
                    state_d      = ST_LOAD;
                    frame_ack_d  = 1'b1;
                    load_start_d = 1'b1;
                    iter_count_d = '0;
                    wdog_d       = '0;
                end
            end
            ST_LOAD: begin
                load_start_d = 1'b1;
                // A rise on the timeout cycle still counts as a successful load.
                if (ld_rise) begin
                    state_d        = ST_DECODE;
                    load_start_d   = 1'b0;
                    decode_start_d = 1'b1;
                end else if (wdog_q == WDOG_W'(LOAD_TIMEOUT - 1)) begin
                    state_d      = ST_IDLE;
                    load_start_d = 1'b0;
                    load_err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            ST_DECODE: begin
                load_start_d = 1'b0;
                if (iter_done) begin
                    iter_count_d = iter_next;
                    if (syndrome_ok || iter_next == ITERWIDTH'(MAXITER)) begin
                        state_d     = ST_UWAIT;
                        converged_d = syndrome_ok;
                    end else begin
                        decode_start_d = 1'b1;
                    end
                end
            end
            ST_UWAIT: begin
                load_start_d = 1'b0;
                if (unload_ready) begin
                    state_d        = ST_UNLOAD;
                    unload_start_d = 1'b1;
                end
            end
            ST_UNLOAD: begin
                load_start_d = 1'b0;
                if (unload_done) begin
                    state_d       = ST_IDLE;
                    frame_count_d = frame_count_q + FRAMEWIDTH'(1);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                load_start_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wdog_q         <= '0;
            frame_ack_q    <= 1'b0;
            load_start_q   <= 1'b0;
            decode_start_q <= 1'b0;
            unload_start_q <= 1'b0;
            iter_count_q   <= '0;
            converged_q    <= 1'b0;
            busy_q         <= 1'b0;
            load_err_q     <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            wdog_q         <= wdog_d;
            frame_ack_q    <= frame_ack_d;
            load_start_q   <= load_start_d;
            decode_start_q <= decode_start_d;
            unload_start_q <= unload_start_d;
            iter_count_q   <= iter_count_d;
            converged_q    <= converged_d;
            busy_q         <= busy_d;
            load_err_q     <= load_err_d;
            frame_count_q  <= frame_count_d;
        end
    end

    assign frame_ack    = frame_ack_q;
    assign load_start   = load_start_q;
    assign decode_start = decode_start_q;
    assign unload_start = unload_start_q;
    assign iter_count   = iter_count_q;
    assign converged    = converged_q;
    assign busy         = busy_q;
    assign load_err     = load_err_q;
    assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_ne_decode_sequencer.sv
// Bench for ne_decode_sequencer: a per-cycle vector table for the basic frame
// flow, then hand-written sequences for the long multi-cycle corner cases.
module tb_ne_decode_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic        load_done = 1'b0;
    logic        iter_done = 1'b0;
    logic        syndrome_ok = 1'b0;
    logic        unload_ready = 1'b0;
    logic        unload_done = 1'b0;
    logic        frame_ack;
    logic        load_start;
    logic        decode_start;
    logic        unload_start;
    logic [3:0]  iter_count;
    logic        converged;
    logic        busy;
    logic        load_err;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ds_cnt   = 0;
    int us_cnt   = 0;
    int exp_fc   = 0;

    typedef struct packed {
        logic rst, fv, ld, id, so, ur, ud;
    } in_t;

    typedef struct packed {
        logic        ack, ls, ds, us;
        logic [3:0]  ic;
        logic        conv, busy, err;
        logic [15:0] fc;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t vecs[$];

    ne_decode_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .frame_valid  (frame_valid),
        .load_done    (load_done),
        .iter_done    (iter_done),
        .syndrome_ok  (syndrome_ok),
        .unload_ready (unload_ready),
        .unload_done  (unload_done),
        .frame_ack    (frame_ack),
        .load_start   (load_start),
        .decode_start (decode_start),
        .unload_start (unload_start),
        .iter_count   (iter_count),
        .converged    (converged),
        .busy         (busy),
        .load_err     (load_err),
        .frame_count  (frame_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "bench timeout");
    end

    function automatic out_t get_out();
        out_t o;
        o = '{ack: frame_ack, ls: load_start, ds: decode_start, us: unload_start,
              ic: iter_count, conv: converged, busy: busy, err: load_err, fc: frame_count};
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: apply inputs, clock once, sample 1 time unit after the edge.
    task automatic drive(input logic fv, input logic ld, input logic id,
                         input logic so, input logic ur, input logic ud);
        frame_valid  = fv;
        load_done    = ld;
        iter_done    = id;
        syndrome_ok  = so;
        unload_ready = ur;
        unload_done  = ud;
        @(posedge clk);
        #1;
        if (decode_start === 1'b1) ds_cnt++;
        if (unload_start === 1'b1) us_cnt++;
    endtask

    task automatic add(input logic r, input logic fv, input logic ld, input logic id,
                       input logic so, input logic ur, input logic ud,
                       input logic ack, input logic ls, input logic ds, input logic us,
                       input logic [3:0] ic, input logic conv, input logic bz,
                       input logic err, input logic [15:0] fc);
        vec_t v;
        v.i = '{rst: r, fv: fv, ld: ld, id: id, so: so, ur: ur, ud: ud};
        v.o = '{ack: ack, ls: ls, ds: ds, us: us, ic: ic, conv: conv, busy: bz, err: err, fc: fc};
        vecs.push_back(v);
    endtask

    initial begin
        //   rst fv ld id so ur ud | ack ls ds us ic conv busy err fc
        add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset
        add(0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 0, 1, 0, 0);  // accept frame
        add(0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 1, 0, 0);  // loading
        add(0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 1, 0, 0);  // load_done rise
        add(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0);  // level held, no re-trigger
        add(0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 1, 0, 1, 0, 0);  // iter 1 fails
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 2, 1, 1, 0, 0);  // iter 2 passes
        add(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 2, 1, 1, 0, 0);  // early unload_done ignored
        add(0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1, 2, 1, 1, 0, 0);  // unload_start
        add(0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 2, 1, 1, 0, 0);  // stray iter_done ignored
        add(0, 1, 0, 0, 0, 0, 1,   0, 0, 0, 0, 2, 1, 0, 0, 1);  // done, fv not taken yet
        add(0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1, 1, 0, 1);  // next frame from IDLE
        add(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);  // reset mid-LOAD
        add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            rst = vecs[k].i.rst;
            drive(vecs[k].i.fv, vecs[k].i.ld, vecs[k].i.id, vecs[k].i.so,
                  vecs[k].i.ur, vecs[k].i.ud);
            chk($sformatf("vec[%0d]", k), 32'(get_out()), 32'(vecs[k].o));
        end
        exp_fc = 0;

        // Nominal: load_done 20 cycles after accept, pass on 3rd iteration
        ds_cnt = 0;
        drive(1, 0, 0, 0, 0, 0);
        chk("nom_ack", 32'(frame_ack), 1);
        repeat (19) drive(0, 0, 0, 0, 0, 0);
        chk("nom_ls_held", 32'(load_start), 1);
        drive(0, 1, 0, 0, 0, 0);
        chk("nom_ds_latency", 32'(decode_start), 1);
        chk("nom_ls_drop", 32'(load_start), 0);
        for (int k = 1; k <= 3; k++) begin
            drive(0, 1, 0, 0, 0, 0);
            drive(0, 1, 1, (k == 3), 0, 0);
        end
        chk("nom_iter", 32'(iter_count), 3);
        chk("nom_conv", 32'(converged), 1);
        chk("nom_ds_pulses", 32'(ds_cnt), 3);
        drive(0, 0, 0, 0, 1, 0);
        chk("nom_us", 32'(unload_start), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("nom_us_pulse", 32'(unload_start), 0);
        drive(0, 0, 0, 0, 0, 1);
        exp_fc++;
        chk("nom_busy", 32'(busy), 0);
        chk("nom_fc", 32'(frame_count), 32'(exp_fc));

        // Exhaustion: syndrome never passes
        ds_cnt = 0;
        us_cnt = 0;
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 0, 0, 0);
            drive(0, 1, 1, 0, 0, 0);
        end
        chk("exh_ds_pulses", 32'(ds_cnt), 8);
        chk("exh_iter", 32'(iter_count), 8);
        chk("exh_conv", 32'(converged), 0);
        chk("exh_no_us_yet", 32'(us_cnt), 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("exh_iter_sat", 32'(iter_count), 8);
        chk("exh_no_extra_ds", 32'(decode_start), 0);
        drive(0, 0, 0, 0, 1, 0);
        chk("exh_us", 32'(unload_start), 1);
        drive(0, 0, 0, 0, 0, 1);
        exp_fc++;
        chk("exh_fc", 32'(frame_count), 32'(exp_fc));

        // Stale load_done high at LOAD entry
        drive(0, 1, 0, 0, 0, 0);
        ds_cnt = 0;
        drive(1, 1, 0, 0, 0, 0);
        repeat (5) drive(0, 1, 0, 0, 0, 0);
        chk("stale_no_ds", 32'(ds_cnt), 0);
        chk("stale_ls", 32'(load_start), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("stale_low_ls", 32'(load_start), 1);
        drive(0, 1, 0, 0, 0, 0);
        chk("stale_rise_ds", 32'(decode_start), 1);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        chk("stale_iter", 32'(iter_count), 1);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        exp_fc++;
        chk("stale_fc", 32'(frame_count), 32'(exp_fc));

        // load_done rise on the exact timeout cycle wins
        drive(1, 0, 0, 0, 0, 0);
        repeat (63) drive(0, 0, 0, 0, 0, 0);
        chk("to_edge_ls", 32'(load_start), 1);
        drive(0, 1, 0, 0, 0, 0);
        chk("to_edge_ds", 32'(decode_start), 1);
        chk("to_edge_err", 32'(load_err), 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        exp_fc++;
        chk("to_edge_fc", 32'(frame_count), 32'(exp_fc));

        // Watchdog: load_done never rises
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (63) drive(0, 0, 0, 0, 0, 0);
        chk("wd_pre_ls", 32'(load_start), 1);
        chk("wd_pre_err", 32'(load_err), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("wd_ls", 32'(load_start), 0);
        chk("wd_err", 32'(load_err), 1);
        chk("wd_busy", 32'(busy), 0);
        chk("wd_fc", 32'(frame_count), 32'(exp_fc));

        // Backpressure in UWAIT
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        us_cnt = 0;
        repeat (30) drive(0, 0, 0, 0, 0, 0);
        chk("bp_no_us", 32'(us_cnt), 0);
        chk("bp_busy", 32'(busy), 1);
        drive(0, 0, 0, 0, 1, 0);
        chk("bp_us", 32'(unload_start), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("bp_us_pulse", 32'(unload_start), 0);
        drive(0, 0, 0, 0, 0, 1);
        exp_fc++;
        chk("bp_fc", 32'(frame_count), 32'(exp_fc));
        chk("bp_err_sticky", 32'(load_err), 1);

        // Reset mid-DECODE at iteration 2
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        chk("rst_pre_iter", 32'(iter_count), 2);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_all_zero", 32'(get_out()), 0);
        rst = 1'b0;
        exp_fc = 0;
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_new_ack", 32'(frame_ack), 1);
        chk("rst_new_iter", 32'(iter_count), 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        chk("rst_new_iter1", 32'(iter_count), 1);
        chk("rst_new_conv", 32'(converged), 1);
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        exp_fc++;
        chk("rst_new_fc", 32'(frame_count), 32'(exp_fc));

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
